// File: rtl/rgb565_pwm_display.sv
// RGB565 switch colour shown two ways: PWM on two RGB LEDs and hex fields
// (blue, green, red from the left) on an 8-digit multiplexed 7-segment display.
module rgb565_pwm_display #(
  parameter int CLKS_PER_DIGIT = 10000,
  parameter int PWM_BITS       = 8
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] SW,
  output logic [2:0]  LED0,
  output logic [2:0]  LED1,
  output logic [7:0]  CA,
  output logic [7:0]  AN
);

  localparam int PW = (CLKS_PER_DIGIT > 1) ? $clog2(CLKS_PER_DIGIT) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(CLKS_PER_DIGIT - 1);

  logic [PW-1:0]       prescaler;
  logic [2:0]          slot;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [3:0]          digit_val;
  logic [7:0]          an_next;
  logic [7:0]          ca_next;
  logic [PWM_BITS-1:0] duty_r;
  logic [PWM_BITS-1:0] duty_g;
  logic [PWM_BITS-1:0] duty_b;
  logic [2:0]          led_q;

  function automatic logic [7:0] hex_to_ca(input logic [3:0] v);
    case (v)
      4'h0: hex_to_ca = 8'hC0;
      4'h1: hex_to_ca = 8'hF9;
      4'h2: hex_to_ca = 8'hA4;
      4'h3: hex_to_ca = 8'hB0;
      4'h4: hex_to_ca = 8'h99;
      4'h5: hex_to_ca = 8'h92;
      4'h6: hex_to_ca = 8'h82;
      4'h7: hex_to_ca = 8'hF8;
      4'h8: hex_to_ca = 8'h80;
      4'h9: hex_to_ca = 8'h90;
      4'hA: hex_to_ca = 8'h88;
      4'hB: hex_to_ca = 8'h83;
      4'hC: hex_to_ca = 8'hC6;
      4'hD: hex_to_ca = 8'hA1;
      4'hE: hex_to_ca = 8'h86;
      default: hex_to_ca = 8'h8E;
    endcase
  endfunction

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      prescaler <= '0;
      slot      <= '0;
      pwm_cnt   <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (prescaler == PRE_MAX) begin
        prescaler <= '0;
        slot      <= slot + 3'd1;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
    end
  end

  // Slots 0 and 1 are the two blank digits on the right.
  always_comb begin
    digit_val = 4'h0;
    an_next   = 8'hFF;
    case (slot)
      3'd2: digit_val = SW[3:0];
      3'd3: digit_val = {3'b000, SW[4]};
      3'd4: digit_val = SW[8:5];
      3'd5: digit_val = {2'b00, SW[10:9]};
      3'd6: digit_val = SW[14:11];
      3'd7: digit_val = {3'b000, SW[15]};
      default: digit_val = 4'h0;
    endcase
    if (slot >= 3'd2) an_next = ~(8'b1 << slot);
    ca_next = (slot >= 3'd2) ? hex_to_ca(digit_val) : 8'hFF;
  end

  // Colour fields are left-justified so full scale sits just below the period.
  assign duty_r = {SW[4:0],   {(PWM_BITS-5){1'b0}}};
  assign duty_g = {SW[10:5],  {(PWM_BITS-6){1'b0}}};
  assign duty_b = {SW[15:11], {(PWM_BITS-5){1'b0}}};

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      AN    <= 8'hFF;
      CA    <= 8'hFF;
      led_q <= 3'b000;
    end else begin
      AN    <= an_next;
      CA    <= ca_next;
      led_q <= {pwm_cnt < duty_b, pwm_cnt < duty_g, pwm_cnt < duty_r};
    end
  end

  assign LED0 = led_q;
  assign LED1 = led_q;

endmodule

// File: tb/tb_rgb565_pwm_display.sv
// Directed bench for rgb565_pwm_display: display scan, hex table, PWM duty and async reset.
module tb_rgb565_pwm_display;

  localparam int N     = 50;
  localparam int FRAME = 8 * N;

  logic        CLK;
  logic        RST;
  logic [15:0] SW;
  logic [2:0]  LED0;
  logic [2:0]  LED1;
  logic [7:0]  CA;
  logic [7:0]  AN;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;
  logic [15:0] exp_q[$];
  logic [7:0]  hex_tbl [16];
  logic [7:0]  pat_ca [6];

  rgb565_pwm_display #(.CLKS_PER_DIGIT(N), .PWM_BITS(8)) dut (
    .CLK(CLK), .RST(RST), .SW(SW), .LED0(LED0), .LED1(LED1), .CA(CA), .AN(AN)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // posedges since reset release; slot k covers cyc in [kN, (k+1)N)
  always @(posedge CLK or negedge RST) begin
    if (!RST) cyc <= 0;
    else      cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic expect_disp(input logic [7:0] an, input logic [7:0] ca);
    exp_q.push_back({an, ca});
  endtask

  task automatic check_disp(input string tag);
    logic [15:0] e;
    if (exp_q.size() == 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL %s observed=empty_queue expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      chk(tag, {16'h0, AN, CA}, {16'h0, e});
    end
  endtask

  // Wait for the middle of the next occurrence of slot s; leaves us at posedge+1.
  task automatic wait_slot(input int s);
    int target;
    int guard;
    target = (cyc / FRAME) * FRAME + s * N + N / 2;
    if (target <= cyc) target += FRAME;
    guard = 0;
    while (cyc < target && guard < 4 * FRAME) begin
      @(posedge CLK);
      #1;
      guard++;
    end
    if (cyc != target) begin
      n_tests++;
      n_fail++;
      $error("FAIL wait_slot%0d observed=%0d expected=%0d", s, cyc, target);
    end
  endtask

  task automatic check_digits(input string name);
    for (int s = 2; s < 8; s++) begin
      expect_disp(~(8'h01 << s), pat_ca[s-2]);
      wait_slot(s);
      check_disp($sformatf("%s_slot%0d", name, s));
    end
  endtask

  task automatic check_pwm(input string name, input int er, input int eg, input int eb);
    int cr, cg, cb, diff;
    cr = 0; cg = 0; cb = 0; diff = 0;
    repeat (3) @(posedge CLK);
    for (int i = 0; i < 256; i++) begin
      @(posedge CLK);
      #1;
      cr += int'(LED0[0]);
      cg += int'(LED0[1]);
      cb += int'(LED0[2]);
      if (LED1 !== LED0) diff++;
    end
    chk({name, "_red_high"},   cr, er);
    chk({name, "_green_high"}, cg, eg);
    chk({name, "_blue_high"},  cb, eb);
    chk({name, "_led1_diff"},  diff, 0);
  endtask

  initial begin
    hex_tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    RST = 1'b0;
    SW  = 16'h7841;
    repeat (4) @(posedge CLK);
    #1;
    chk("rst_led0", {29'h0, LED0}, 32'h0);
    chk("rst_led1", {29'h0, LED1}, 32'h0);
    chk("rst_an",   {24'h0, AN},   32'hFF);
    chk("rst_ca",   {24'h0, CA},   32'hFF);
    @(negedge CLK);
    RST = 1'b1;

    // blank slots after release, then 7841 digits
    expect_disp(8'hFF, 8'hFF);
    wait_slot(0);
    check_disp("blank_slot0");
    expect_disp(8'hFF, 8'hFF);
    wait_slot(1);
    check_disp("blank_slot1");
    pat_ca = '{8'hF9, 8'hC0, 8'hA4, 8'hC0, 8'h8E, 8'hC0};
    check_digits("sw7841");
    check_pwm("pwm7841", 8, 8, 120);

    @(negedge CLK);
    SW = 16'hFFFF;
    pat_ca = '{8'h8E, 8'hF9, 8'h8E, 8'hB0, 8'h8E, 8'hF9};
    check_digits("swFFFF");
    check_pwm("pwmFFFF", 248, 252, 248);

    @(negedge CLK);
    SW = 16'h0000;
    pat_ca = '{8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0, 8'hC0};
    check_digits("sw0000");
    check_pwm("pwm0000", 0, 0, 0);

    // nibble sweep on the red digit with one-cycle latency
    wait_slot(2);
    for (int i = 0; i < 16; i++) begin
      @(negedge CLK);
      SW[3:0] = 4'(i);
      #1;
      if (i > 0) chk($sformatf("sweep_hold%0d", i), {24'h0, CA}, {24'h0, hex_tbl[i-1]});
      @(posedge CLK);
      #1;
      chk($sformatf("sweep_hex%0d", i), {24'h0, CA}, {24'h0, hex_tbl[i]});
    end
    chk("sweep_an", {24'h0, AN}, 32'hFB);

    // async reset in slot 5
    @(negedge CLK);
    SW = 16'hFFFF;
    expect_disp(8'hDF, 8'hB0);
    wait_slot(5);
    check_disp("pre_rst_slot5");
    #3;
    RST = 1'b0;
    #1;
    chk("async_an",   {24'h0, AN},   32'hFF);
    chk("async_ca",   {24'h0, CA},   32'hFF);
    chk("async_led0", {29'h0, LED0}, 32'h0);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;

    expect_disp(8'hFF, 8'hFF);
    wait_slot(0);
    check_disp("restart_slot0");
    chk("restart_cyc", cyc, N / 2);
    expect_disp(8'hFB, 8'h8E);
    wait_slot(2);
    check_disp("restart_slot2");
    expect_disp(8'h7F, 8'hF9);
    wait_slot(7);
    check_disp("restart_slot7");
    expect_disp(8'hFF, 8'hFF);
    wait_slot(0);
    check_disp("frame2_slot0");
    chk("frame2_cyc", cyc, FRAME + N / 2);
    expect_disp(8'hFB, 8'h8E);
    wait_slot(2);
    check_disp("frame2_slot2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
